// File: rtl/opb_register_bank_ppc2simulink.sv
`default_nettype none
// ============================================================================
// Module   : opb_register_bank_ppc2simulink
// Brief    : NUM_REGS x 32-bit OPB slave register bank (level, pulse, status)
//            feeding Simulink user logic in the OPB clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          NUM_REGS     = 8,
    parameter logic [63:0] PULSE_MASK   = 64'h0,
    parameter logic [63:0] RO_MASK      = 64'h0,
    parameter logic [31:0] RST_VALUE    = 32'h0000_0000
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [32*NUM_REGS-1:0]    user_data_out,
    output logic [NUM_REGS-1:0]       user_wr_stb,
    input  logic [32*NUM_REGS-1:0]    user_data_in
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_ack;
    logic [31:0] r_rdata;
    logic        r_rnw;
    logic        r_in_bank;
    logic [29:0] r_idx;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;

    logic [31:0] w_addr;
    logic [31:0] w_offset;
    logic [29:0] w_idx;
    logic        w_hit;
    logic        w_in_bank;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [31:0] w_rd_val;
    logic        w_wr_go;
    logic        w_unused;

    // Vector assignment maps OPB bit 0 (MSB) onto register bit 31 directly.
    assign w_addr    = OPB_ABus;
    assign w_wdata   = OPB_DBus;
    assign w_be      = OPB_BE;
    assign w_offset  = w_addr - C_BASEADDR;
    assign w_idx     = w_offset[31:2];
    assign w_hit     = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
    assign w_in_bank = (w_idx < 30'(NUM_REGS));
    assign w_unused  = ^{OPB_seqAddr, w_offset[1:0], user_data_in};

    always_comb begin
        w_rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_in_bank && (w_idx == 30'(i))) begin
                if (RO_MASK[i])
                    w_rd_val = user_data_in[32*i +: 32];
                else if (PULSE_MASK[i])
                    w_rd_val = RST_VALUE;
                else
                    w_rd_val = user_data_out[32*i +: 32];
            end
        end
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            r_state   <= S_IDLE;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
            r_rnw     <= 1'b1;
            r_in_bank <= 1'b0;
            r_idx     <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_state   <= S_ACK;
                        r_ack     <= 1'b1;
                        r_rnw     <= OPB_RNW;
                        r_in_bank <= w_in_bank;
                        r_idx     <= w_idx;
                        r_be      <= w_be;
                        r_wdata   <= w_wdata;
                        r_rdata   <= OPB_RNW ? w_rd_val : 32'h0;
                    end
                end
                S_ACK: begin
                    // Select may still be high here; it is deliberately not re-decoded.
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_rdata <= '0;
                end
            endcase
        end
    end

    assign w_wr_go = (r_state == S_ACK) && !r_rnw && r_in_bank;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign user_data_out[32*i +: 32] = RST_VALUE;
            assign user_wr_stb[i]            = 1'b0;
        end else begin : g_rw
            logic [31:0] r_value;
            logic        r_stb;
            logic        w_sel;
            logic [31:0] w_merged;

            assign w_sel = w_wr_go && (r_idx == 30'(i));

            always_comb begin
                w_merged = r_value;
                for (int b = 0; b < 4; b++) begin
                    if (r_be[b])
                        w_merged[8*b +: 8] = r_wdata[8*b +: 8];
                end
            end

            always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
                if (!OPB_Rst_n) begin
                    r_value <= RST_VALUE;
                    r_stb   <= 1'b0;
                end else begin
                    r_stb <= w_sel;
                    if (w_sel)
                        r_value <= w_merged;
                    else if (PULSE_MASK[i])
                        r_value <= RST_VALUE;
                end
            end

            assign user_data_out[32*i +: 32] = r_value;
            assign user_wr_stb[i]            = r_stb;
        end
    end

    assign Sl_DBus    = r_rdata;
    assign Sl_xferAck = r_ack;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_opb_register_bank_ppc2simulink.sv
`default_nettype none
// ============================================================================
// Module   : tb_opb_register_bank_ppc2simulink
// Brief    : Directed and random OPB transfers checked against a register model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opb_register_bank_ppc2simulink;

    localparam int          NR    = 8;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] HIGH  = 32'h0000_10FF;
    localparam logic [31:0] RSTV  = 32'hA5A5_A5A5;
    localparam logic [63:0] PMASK = 64'h2;
    localparam logic [63:0] RMASK = 64'h4;

    logic              clk;
    logic              rst_n;
    logic [0:31]       abus;
    logic [0:3]        be;
    logic [0:31]       dbus;
    logic              rnw;
    logic              sel;
    logic              seq;
    logic [0:31]       sl_dbus;
    logic              ack;
    logic              err_ack;
    logic              retry;
    logic              tout;
    logic [32*NR-1:0]  udo;
    logic [NR-1:0]     stb;
    logic [32*NR-1:0]  udi;

    int          n_pass;
    int          n_total;
    int          n_fail;
    logic [31:0] m_reg [NR];
    logic [255:0] keep;
    logic [31:0] rd;

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .NUM_REGS     (NR),
        .PULSE_MASK   (PMASK),
        .RO_MASK      (RMASK),
        .RST_VALUE    (RSTV)
    ) dut (
        .OPB_Clk       (clk),
        .OPB_Rst_n     (rst_n),
        .OPB_ABus      (abus),
        .OPB_BE        (be),
        .OPB_DBus      (dbus),
        .OPB_RNW       (rnw),
        .OPB_select    (sel),
        .OPB_seqAddr   (seq),
        .Sl_DBus       (sl_dbus),
        .Sl_xferAck    (ack),
        .Sl_errAck     (err_ack),
        .Sl_retry      (retry),
        .Sl_toutSup    (tout),
        .user_data_out (udo),
        .user_wr_stb   (stb),
        .user_data_in  (udi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model_out(input int vis, input logic [31:0] visv);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < NR; i++)
            v[32*i +: 32] = (i == vis) ? visv : m_reg[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_reg[i] = RSTV;
    endtask

    // Starts and ends on a falling edge; checks ack, read data, strobe and outputs.
    task automatic xfer(input logic [31:0] addr, input logic r, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] obs_rd);
        int          idx;
        logic        inb;
        logic        ro;
        logic        pulse;
        logic [31:0] exp_rd;
        logic [31:0] merged;
        logic [7:0]  exp_stb;
        int          vis;
        logic [31:0] visv;
        idx     = int'((addr - BASE) >> 2);
        inb     = (idx < NR);
        ro      = inb && RMASK[idx];
        pulse   = inb && PMASK[idx] && !ro;
        exp_rd  = 32'h0;
        exp_stb = 8'h0;
        vis     = -1;
        visv    = 32'h0;
        if (r && inb)
            exp_rd = ro ? udi[32*idx +: 32] : (pulse ? RSTV : m_reg[idx]);
        if (!r && inb && !ro) begin
            merged = m_reg[idx];
            for (int k = 0; k < 4; k++)
                if (b[k]) merged[8*k +: 8] = d[8*k +: 8];
            exp_stb[idx] = 1'b1;
            if (pulse) begin
                vis  = idx;
                visv = merged;
            end else begin
                m_reg[idx] = merged;
            end
        end
        abus = addr; be = b; dbus = d; rnw = r; sel = 1'b1;
        @(negedge clk);
        check("ack_high", ack, 1);
        check("read_data", sl_dbus, exp_rd);
        check("stb_in_ack", stb, 0);
        obs_rd = sl_dbus;
        sel = 1'b0; abus = $urandom; dbus = $urandom; be = 4'($urandom); rnw = 1'($urandom);
        @(negedge clk);
        check("ack_low", ack, 0);
        check("dbus_idle", sl_dbus, 0);
        check("strobe", stb, exp_stb);
        check("user_out_new", udo & keep, model_out(vis, visv) & keep);
        @(negedge clk);
        check("strobe_clear", stb, 0);
        check("user_out_settled", udo & keep, model_out(-1, 32'h0) & keep);
    endtask

    initial begin
        n_pass = 0; n_total = 0; n_fail = 0;
        keep = '0;
        for (int i = 0; i < NR; i++)
            if (!RMASK[i]) keep[32*i +: 32] = 32'hFFFF_FFFF;
        model_reset();
        rst_n = 1'b0; sel = 1'b0; seq = 1'b0; rnw = 1'b1; be = 4'h0;
        abus = '0; dbus = '0; udi = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_dbus", sl_dbus, 0);
        check("rst_stb", stb, 0);
        check("rst_user_out", udo & keep, model_out(-1, 32'h0) & keep);
        check("tied_outputs", {err_ack, retry, tout}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Read of reset value
        xfer(BASE, 1'b1, 4'hF, 32'h0, rd);
        check("reset_readback", rd, 32'hA5A5_A5A5);

        // Byte-enable merge on a level register
        xfer(BASE + 12, 1'b0, 4'b1111, 32'h1234_5678, rd);
        xfer(BASE + 12, 1'b0, 4'b0100, 32'hFFFF_FFFF, rd);
        xfer(BASE + 12, 1'b1, 4'hF, 32'h0, rd);
        check("be_merge", rd, 32'h12FF_5678);

        // Pulse register
        xfer(BASE + 4, 1'b0, 4'hF, 32'h0000_0001, rd);
        xfer(BASE + 4, 1'b1, 4'hF, 32'h0, rd);
        check("pulse_readback", rd, RSTV);

        // Read-only status register
        udi[64 +: 32] = 32'hDEAD_BEEF;
        xfer(BASE + 8, 1'b0, 4'hF, 32'h0, rd);
        xfer(BASE + 8, 1'b1, 4'hF, 32'h0, rd);
        check("ro_readback", rd, 32'hDEAD_BEEF);

        // In window but beyond the bank
        xfer(BASE + 32, 1'b0, 4'hF, 32'hCAFE_F00D, rd);
        xfer(BASE + 33, 1'b1, 4'hF, 32'h0, rd);
        check("beyond_bank_read", rd, 32'h0);

        // Outside the window: never acked
        abus = HIGH + 1; rnw = 1'b1; be = 4'hF; sel = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("outside_high_noack", ack, 0);
        end
        abus = BASE - 4;
        repeat (2) begin
            @(negedge clk);
            check("outside_low_noack", ack, 0);
        end
        sel = 1'b0;
        @(negedge clk);

        // Reset dropped in the ack cycle of a write
        abus = BASE + 20; rnw = 1'b0; be = 4'hF; dbus = 32'h0BAD_0BAD; sel = 1'b1;
        @(negedge clk);
        check("pre_abort_ack", ack, 1);
        sel = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("abort_ack", ack, 0);
        check("abort_dbus", sl_dbus, 0);
        check("abort_user_out", udo & keep, model_out(-1, 32'h0) & keep);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(BASE + 20, 1'b1, 4'hF, 32'h0, rd);
        check("post_abort_reg5", rd, RSTV);
        xfer(BASE + 12, 1'b1, 4'hF, 32'h0, rd);
        check("post_abort_reg3", rd, RSTV);

        // Random traffic including out-of-bank indices and unaligned low bits
        for (int t = 0; t < 80; t++) begin
            int          ridx;
            logic [31:0] raddr;
            for (int i = 0; i < NR; i++) udi[32*i +: 32] = $urandom;
            ridx  = int'($urandom_range(0, 9));
            raddr = BASE + 32'(ridx * 4) + 32'($urandom_range(0, 3));
            xfer(raddr, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
